// File: rtl/cv32e40p_obi_mem_responder_if.sv
// OBI bus bundle between a core-side master and the memory responder.
// Handshake: a request transfers on every cycle where obi_req_i && obi_gnt_o
// are both high; the master must hold its request fields stable until granted.
// Responses are fire-and-forget: obi_rvalid_o is a one-cycle pulse with no
// ready, so the master must always accept it.
interface cv32e40p_obi_mem_responder_if;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic [5:0]  obi_atop_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;

  modport master (
    output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_atop_i,
    input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o
  );

  modport slave (
    input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_atop_i,
    output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o
  );
endinterface

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory responder: terminates an OBI port in a word-addressed scratchpad.
// Grants after GNT_WAIT cycles of req, performs the access on the handshake
// edge and answers in order exactly RESP_LAT cycles later.
// Optional macro OBI_RESP_RANDOM_STALL_EN adds an LFSR that randomly withholds
// grants (the grant FSM holds its state while stalled).
module cv32e40p_obi_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned GNT_WAIT  = 0,
  parameter int unsigned RESP_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cv32e40p_obi_mem_responder_if.slave bus,
  output logic                        dbg_state_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(GNT_WAIT + 2);
  localparam logic [CNT_W-1:0] GW_C = CNT_W'(GNT_WAIT);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stall;
  logic                gnt_raw;
  logic                gnt;
  logic                hs;
  logic [IDX_W-1:0]    idx;
  logic                acc_err;
  logic                mem_we;
  logic [31:0]         mem_q [MEM_WORDS];
  resp_t               pipe_q [RESP_LAT];
  resp_t               pipe_d [RESP_LAT];

`ifdef OBI_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11; the new bit enters at bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, seeded to a fixed non-zero value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Grant FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant FSM next state: count req cycles; a stalled grant holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (GNT_WAIT != 0) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.obi_req_i) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (!bus.obi_req_i) begin
            // Master withdrew its request: abandon it without an access.
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q < GW_C) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (!stall) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Grant FSM outputs; grant is held low while reset is asserted.
  always_comb begin
    gnt_raw = 1'b0;
    if (GNT_WAIT == 0) gnt_raw = bus.obi_req_i && (state_q == S_IDLE);
    else               gnt_raw = bus.obi_req_i && (state_q == S_WAIT) && (cnt_q == GW_C);
    gnt         = rst_n && gnt_raw && !stall;
    dbg_state_o = state_q;
  end

  assign bus.obi_gnt_o = gnt;
  assign hs            = bus.obi_req_i && gnt;
  assign idx           = bus.obi_addr_i[IDX_W+1:2];
  assign acc_err       = ({1'b0, bus.obi_addr_i} >= MEM_BYTES) || bus.obi_atop_i[5];
  assign mem_we        = hs && bus.obi_we_i && !acc_err;

  // Scratchpad byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.obi_be_i[b]) mem_q[idx][8*b +: 8] <= bus.obi_wdata_i[8*b +: 8];
      end
    end
  end

  // Response pipeline input (pre-write read data) and shift path.
  always_comb begin
    pipe_d[0].valid = hs;
    pipe_d[0].err   = hs && acc_err;
    pipe_d[0].rdata = (hs && !bus.obi_we_i && !acc_err) ? mem_q[idx] : 32'h0;
    for (int i = 1; i < RESP_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Response pipeline register; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_LAT; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < RESP_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign bus.obi_rvalid_o = pipe_q[RESP_LAT-1].valid;
  assign bus.obi_err_o    = pipe_q[RESP_LAT-1].err;
  assign bus.obi_rdata_o  = pipe_q[RESP_LAT-1].rdata;

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Directed bench for cv32e40p_obi_mem_responder. Three instances cover
// (GNT_WAIT,RESP_LAT) = (0,1), (2,1) and (0,3); one shared driver is routed to
// the selected instance and its outputs are muxed back to the checker.
module tb_cv32e40p_obi_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared driver signals ----------------
  logic [1:0]  sel;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [5:0]  atop;
  logic        gnt, rvalid, err, dbg_state;
  logic [31:0] rdata;
  logic        dbg_a, dbg_b, dbg_c;

  int n_tests = 0;
  int n_fail  = 0;

  // {expected cycle, err, rdata}
  logic [64:0] exp_q[$];

  cv32e40p_obi_mem_responder_if bus_a ();
  cv32e40p_obi_mem_responder_if bus_b ();
  cv32e40p_obi_mem_responder_if bus_c ();

  assign bus_a.obi_req_i = req && (sel == 2'd0);
  assign bus_b.obi_req_i = req && (sel == 2'd1);
  assign bus_c.obi_req_i = req && (sel == 2'd2);
  assign bus_a.obi_addr_i = addr;   assign bus_b.obi_addr_i = addr;   assign bus_c.obi_addr_i = addr;
  assign bus_a.obi_we_i = we;       assign bus_b.obi_we_i = we;       assign bus_c.obi_we_i = we;
  assign bus_a.obi_be_i = be;       assign bus_b.obi_be_i = be;       assign bus_c.obi_be_i = be;
  assign bus_a.obi_wdata_i = wdata; assign bus_b.obi_wdata_i = wdata; assign bus_c.obi_wdata_i = wdata;
  assign bus_a.obi_atop_i = atop;   assign bus_b.obi_atop_i = atop;   assign bus_c.obi_atop_i = atop;

  assign gnt = (sel == 2'd0) ? bus_a.obi_gnt_o : (sel == 2'd1) ? bus_b.obi_gnt_o : bus_c.obi_gnt_o;
  assign rvalid = (sel == 2'd0) ? bus_a.obi_rvalid_o : (sel == 2'd1) ? bus_b.obi_rvalid_o : bus_c.obi_rvalid_o;
  assign rdata = (sel == 2'd0) ? bus_a.obi_rdata_o : (sel == 2'd1) ? bus_b.obi_rdata_o : bus_c.obi_rdata_o;
  assign err = (sel == 2'd0) ? bus_a.obi_err_o : (sel == 2'd1) ? bus_b.obi_err_o : bus_c.obi_err_o;
  assign dbg_state = (sel == 2'd0) ? dbg_a : (sel == 2'd1) ? dbg_b : dbg_c;

  cv32e40p_obi_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(0), .RESP_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state_o(dbg_a)
  );
  cv32e40p_obi_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(2), .RESP_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state_o(dbg_b)
  );
  cv32e40p_obi_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(0), .RESP_LAT(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c), .dbg_state_o(dbg_c)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'd2) ? 3 : 1;
  endfunction

  // Scoreboard: every rvalid must match the oldest expectation, on its cycle.
  always @(negedge clk) begin : monitor
    logic [64:0] e;
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 64'(rvalid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_cycle", 64'(cyc), 64'(e[64:33]));
        check("resp_err", 64'(err), 64'(e[32]));
        check("resp_rdata", 64'(rdata), 64'(e[31:0]));
      end
    end else begin
      check("idle_rdata", 64'(rdata), 64'd0);
      check("idle_err", 64'(err), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Present one request, wait (bounded) for grant, check the grant delay and
  // queue the expected response. req stays high for back-to-back use.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [5:0] at,
                      input logic [31:0] e_rdata, input logic e_err,
                      input int e_wait, input string tag);
    int waits = 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d; atop = at;
    #1;
    while (gnt !== 1'b1 && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check({tag, "_gnt_wait"}, 64'(waits), 64'(e_wait));
    if (gnt === 1'b1) exp_q.push_back({32'(cyc + lat_of(sel)), e_err, e_rdata});
    else req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    sel = 2'd0; req = 1'b1; we = 1'b0; addr = '0; be = '0; wdata = '0; atop = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    // Reset values (req held high: grant must stay low in reset).
    for (int s = 0; s < 3; s++) begin
      sel = s[1:0];
      #1;
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
    end
    sel = 2'd0;
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Write then immediate read of the same word, zero wait, latency 1.
    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 6'h0, 32'h0,        1'b0, 0, "t1_wr");
    xfer(1'b0, 32'h10, 4'hF, 32'h0,        6'h0, 32'hDEADBEEF, 1'b0, 0, "t1_rd");
    idle(3);

    // Partial byte-lane write; low address bits are ignored.
    xfer(1'b1, 32'h20, 4'hF,    32'h11223344, 6'h0, 32'h0,        1'b0, 0, "t2_pre");
    xfer(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 6'h0, 32'h0,        1'b0, 0, "t2_wr");
    xfer(1'b0, 32'h20, 4'hF,    32'h0,        6'h0, 32'h11BB33DD, 1'b0, 0, "t2_rd");
    xfer(1'b0, 32'h23, 4'h0,    32'h0,        6'h0, 32'h11BB33DD, 1'b0, 0, "t2_rd_unal");
    idle(3);

    // Error cases: out-of-range address and atomics; no write may happen.
    xfer(1'b1, 32'h0,    4'hF, 32'h12345678, 6'h0,  32'h0,        1'b0, 0, "t5_pre0");
    xfer(1'b1, 32'hFFC,  4'hF, 32'hA5A5A5A5, 6'h0,  32'h0,        1'b0, 0, "t5_prelast");
    xfer(1'b0, 32'hFFC,  4'hF, 32'h0,        6'h0,  32'hA5A5A5A5, 1'b0, 0, "t5_rdlast");
    xfer(1'b0, 32'h1000, 4'hF, 32'h0,        6'h0,  32'h0,        1'b1, 0, "t5_rd_oor");
    xfer(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 6'h0,  32'h0,        1'b1, 0, "t5_wr_oor");
    xfer(1'b1, 32'h0,    4'hF, 32'hFFFFFFFF, 6'h20, 32'h0,        1'b1, 0, "t5_wr_atop");
    xfer(1'b0, 32'h0,    4'hF, 32'h0,        6'h20, 32'h0,        1'b1, 0, "t5_rd_atop");
    xfer(1'b0, 32'h0,    4'hF, 32'h0,        6'h0,  32'h12345678, 1'b0, 0, "t5_rd0");
    idle(3);

    // Grant wait of 2 on instance b, including back-to-back requests.
    sel = 2'd1;
    xfer(1'b1, 32'h8, 4'hF, 32'h0BADF00D, 6'h0, 32'h0,        1'b0, 2, "t3_wr");
    xfer(1'b0, 32'h8, 4'hF, 32'h0,        6'h0, 32'h0BADF00D, 1'b0, 2, "t3_rd");
    idle(3);
    // Request withdrawn after one cycle: no grant, FSM returns to IDLE.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h8;
    #1;
    check("t3_drop_gnt0", 64'(gnt), 64'd0);
    check("t3_drop_idle0", 64'(dbg_state), 64'd0);
    @(negedge clk);
    req = 1'b0;
    #1;
    check("t3_drop_gnt1", 64'(gnt), 64'd0);
    check("t3_drop_wait", 64'(dbg_state), 64'd1);
    @(negedge clk);
    #1;
    check("t3_drop_idle", 64'(dbg_state), 64'd0);
    idle(4);
    xfer(1'b0, 32'h8, 4'hF, 32'h0, 6'h0, 32'h0BADF00D, 1'b0, 2, "t3_rd_after");
    idle(3);

    // Latency 3 on instance c: back-to-back writes, then reads.
    sel = 2'd2;
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'(4 * i), 4'hF, 32'hA0000000 | 32'(i), 6'h0, 32'h0, 1'b0, 0, "t4_wr");
    for (int i = 0; i < 4; i++)
      xfer(1'b0, 32'(4 * i), 4'hF, 32'h0, 6'h0, 32'hA0000000 | 32'(i), 1'b0, 0, "t4_rd");
    idle(6);

    // Reset with two reads in flight.
    xfer(1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 6'h0, 32'h0, 1'b0, 0, "t6_wr");
    idle(5);
    xfer(1'b0, 32'h40, 4'hF, 32'h0, 6'h0, 32'hCAFEF00D, 1'b0, 0, "t6_rd0");
    xfer(1'b0, 32'h0,  4'hF, 32'h0, 6'h0, 32'hA0000000, 1'b0, 0, "t6_rd1");
    @(negedge clk);
    req = 1'b1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_gnt", 64'(gnt), 64'd0);
    check("t6_rst_rvalid", 64'(rvalid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("t6_rst_gnt_hold", 64'(gnt), 64'd0);
      check("t6_rst_rvalid_hold", 64'(rvalid), 64'd0);
    end
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    idle(6);
    #1;
    check("t6_state_idle", 64'(dbg_state), 64'd0);
    xfer(1'b0, 32'h40, 4'hF, 32'h0, 6'h0, 32'hCAFEF00D, 1'b0, 0, "t6_rd_keep");
    idle(5);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cv32e40p_obi_mem_responder.md
Name: cv32e40p_obi_mem_responder

Overview:
- OBI responder (memory side) that terminates the core's OBI data/instruction port in an internal word-addressed scratchpad.
- Grants requests after a configurable wait, performs the access on the handshake cycle, and returns rvalid/rdata/err in order after a fixed latency.
- Used as the standard memory endpoint in core-level benches and in small FPGA builds.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in the scratchpad; power of two, >= 2.
- GNT_WAIT, 0: number of cycles req must be high before gnt is asserted; 0 means same-cycle gnt.
- RESP_LAT, 1: number of cycles from handshake to rvalid; >= 1, <= 8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, reset asynchronous active-low.
- obi_req_i  in  1  request valid.
- obi_gnt_o  out  1  grant.
- obi_addr_i  in  32  byte address.
- obi_we_i  in  1  1 = write, 0 = read.
- obi_be_i  in  4  byte enables.
- obi_wdata_i  in  32  write data.
- obi_atop_i  in  6  atomic op; bit5 = 1 marks an atomic.
- obi_rvalid_o  out  1  response valid.
- obi_rdata_o  out  32  read data; 0 when rvalid = 0 and for writes.
- obi_err_o  out  1  response error; 0 when rvalid = 0.

Behaviour:
- Reset values: gnt 0, rvalid 0, rdata 0, err 0, FSM IDLE, wait counter 0, response pipeline empty. Scratchpad contents are not reset.
- Handshake is req && gnt. Address/we/be/wdata/atop are sampled only on the handshake cycle.
- Grant FSM, states IDLE and WAIT:
  - GNT_WAIT = 0: gnt = req combinationally in IDLE; the FSM never leaves IDLE.
  - GNT_WAIT > 0, IDLE: req=1 -> WAIT, cnt = 1, gnt 0.
  - WAIT, cnt < GNT_WAIT: cnt++, gnt 0.
  - WAIT, cnt == GNT_WAIT: gnt = 1 that cycle -> IDLE.
  - WAIT, req dropped before grant (protocol violation): -> IDLE, counter cleared, no access, no response.
  - Back-to-back requests with GNT_WAIT > 0 pay the full wait on every transaction.
- Access on handshake:
  - Word index = addr[log2(MEM_WORDS)+1:2]; addr[1:0] ignored.
  - Write: each byte lane with be set is updated at the clock edge.
  - Read: returns the word as it was before any write in the same edge.
  - A read in the cycle after a write to the same word returns the new data.
- Error: err = 1 when addr >= MEM_WORDS*4, or when atop[5] = 1.
  - An erroneous transaction is still granted and answered.
  - No write occurs; rdata = 0.
- Response pipeline: RESP_LAT-stage shift register carrying {valid, err, rdata}.
  - rvalid is asserted exactly RESP_LAT cycles after the handshake, for exactly 1 cycle.
  - One response per handshake, strictly in order.
  - Back-to-back handshakes give back-to-back rvalid.
  - There is no rready; the responder never stalls responses.
- Max outstanding transactions = RESP_LAT. No counter is needed because latency is fixed.
- Reset mid-operation: all in-flight responses are dropped and the FSM returns to IDLE. Memory keeps its contents.
- Simultaneous response and new handshake in the same cycle: both are legal and independent.

Optional Feature:
- Macro OBI_RESP_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances every cycle.
  - In any cycle that would otherwise grant, gnt is forced 0 when lfsr[0] = 1. The FSM holds its state and counter.
  - Response latency is unchanged.
- Undefined: no LFSR logic; grant timing is exactly as above.

Test Plan:
1. GNT_WAIT=0, RESP_LAT=1: write addr 0x10, be 4'hF, wdata 32'hDEADBEEF, then read 0x10 -> gnt same cycle each time; read rvalid 1 cycle after grant with rdata 32'hDEADBEEF, err 0. The write's response has rdata 0.
2. Partial write: preload 0x20 = 32'h11223344, write be 4'b0101 wdata 32'hAABBCCDD, read 0x20 -> 32'h11BB33DD.
3. GNT_WAIT=2: req held high -> gnt exactly on the 3rd req cycle. Req dropped after 1 cycle -> no gnt, no rvalid, FSM back in IDLE.
4. RESP_LAT=3: four back-to-back reads of 0x0/0x4/0x8/0xC -> rvalid on 4 consecutive cycles starting 3 cycles after the first grant, data in order.
5. Errors with MEM_WORDS=1024: read 0x1000 -> err 1, rdata 0. Write with atop 6'h20 to 0x0 -> err 1 and location 0x0 unchanged.
6. Reset asserted while 2 responses are in flight (RESP_LAT=3) -> no rvalid after reset release; gnt 0 during reset. Earlier-written data is still readable afterwards.
